lsram_port_arbiter: RTL and testbench
=====================================

// Module: lsram_port_arbiter
// PURPOSE
//  Shares one LSRAM control port (req/ack/write/size/addr/wdata/rdata) between two requesters:
//  port 0 = AHB slave interface, port 1 = secondary master (bootloader/bridge loader).
//  Round-robin or fixed-priority arbitration, one access in flight, ack watchdog with error flag.
//  Sits between the requesters and the SRAM controller; drives that controller as its single client.
// PARAMETERS
//  MEM_AWIDTH   19    memory byte-address width
//  DWIDTH       32    data width
//  FIXED_PRIO   0     0 = round-robin; 1 = port 0 always wins a tie
//  TIMEOUT_CYC  255   cycles in WAIT without mem_ack before forced completion with error (1..255)
// PORTS
//  HCLK        in   1           clock; all logic on rising edge
//  HRESET      in   1           asynchronous, active-high reset
//  req0/req1   in   1           level request; held until ackN seen, dropped on the edge closing the ack cycle
//  wr0/wr1     in   1           1 = write
//  size0/size1 in   3           AHB HSIZE encoding (000 byte, 001 half, 010 word)
//  addr0/addr1 in   MEM_AWIDTH  byte address
//  wdata0/1    in   DWIDTH      write data
//  ack0/ack1   out  1           one-cycle completion pulse to requester
//  err0/err1   out  1           valid with ackN: 1 = watchdog expired, no mem_ack
//  rdata       out  DWIDTH      registered read data, valid with ack0/ack1
//  mem_req     out  1           one-cycle request pulse to SRAM controller
//  mem_write   out  1           latched write flag of granted requester
//  mem_size    out  3           latched size
//  mem_addr    out  MEM_AWIDTH  latched address
//  mem_wdata   out  DWIDTH      latched write data
//  mem_ack     in   1           SRAM controller completion (may assert in the mem_req cycle)
//  mem_rdata   in   DWIDTH      read data, valid while mem_ack=1
//  grant       out  1           id of current/last granted port
//  busy        out  1           1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last_grant=1 (so port 0 wins first round-robin tie); timer=0.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: if req0|req1, select winner; latch wr/size/addr/wdata into mem_* regs and set grant; go ISSUE.
//   Both requesting: FIXED_PRIO=1 -> port 0; else the port != last_grant. Single requester always wins.
//  ISSUE: mem_req=1 (exactly one cycle). If mem_ack=1 this cycle, capture mem_rdata, go DONE; else go WAIT.
//  WAIT: mem_req=0; timer increments each cycle. mem_ack=1 -> capture mem_rdata, err=0, go DONE.
//   timer==TIMEOUT_CYC-1 without ack -> rdata=0, err=1, go DONE. Late mem_ack after timeout ignored.
//  DONE: ack[grant]=1, err[grant]=flag for this single cycle; last_grant<=grant; timer<=0; go IDLE.
//  Min latency: req high in cycle T (IDLE) -> mem_req T+1 -> ack T+2 if mem_ack in ISSUE cycle.
//  mem_* command regs stable from ISSUE through DONE; change only on an IDLE grant.
//  Request inputs ignored outside IDLE; a req dropped before grant is simply not served (no error).
//  rdata holds last value until next DONE; on write accesses rdata takes mem_rdata as presented.
//  ack0 and ack1 never assert together; at most one access outstanding.
//  HRESET mid-access: immediate return to IDLE, no ack/err issued; aborted requester must re-request.
// TESTING
//  1 Port 0 read addr 0x00010, mem_ack in ISSUE, mem_rdata=0xDEADBEEF -> mem_req 1 cycle, ack0 at T+2, rdata=0xDEADBEEF.
//  2 req0&req1 held together, RR, 4 accesses -> grants 0,1,0,1; FIXED_PRIO=1 -> port 1 starves while req0 held.
//  3 Port 1 byte write addr 0x7FFFF wdata 0x000000A5, ack after 5 WAIT cycles -> mem_addr=0x7FFFF, mem_size=000, ack1 1 cycle.
//  4 TIMEOUT_CYC=8, no mem_ack -> ack0 & err0 at 8th WAIT cycle+1, rdata=0; late mem_ack ignored, next grant clean.
//  5 HRESET asserted during WAIT -> all outputs 0 next edge, no ack; after release new req0 served normally.
//  6 Change addr0 while in WAIT -> mem_addr unchanged until next IDLE grant.

Source files
------------

// File: rtl/lsram_port_arbiter.sv
// ---------------------------------------------------------------------------
// lsram_port_arbiter
// Shares one LSRAM control port between two requesters. Port 0 is the AHB
// slave interface and port 1 is the secondary master (bootloader/bridge
// loader). The block is the only client of the SRAM controller and allows
// one access in flight. Simultaneous requests are resolved round-robin, or
// by fixed priority to port 0. A watchdog forces completion with an error
// flag when the controller never acknowledges.
//
// Ports
//   HCLK, HRESET          clock (rising edge), async active-high reset
//   reqN/wrN/sizeN/addrN/wdataN  requester N command (level request)
//   ackN / errN           one-cycle completion pulse / watchdog-expired flag
//   rdata                 registered read data, valid with ackN
//   mem_req               one-cycle request pulse to the SRAM controller
//   mem_write/size/addr/wdata  command latched at grant time
//   mem_ack / mem_rdata   controller completion and read data
//   grant                 id of the current/last granted port
//   busy                  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module lsram_port_arbiter #(
  parameter int MEM_AWIDTH  = 19,
  parameter int DWIDTH      = 32,
  parameter int FIXED_PRIO  = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [2:0]            size0,
  input  logic [2:0]            size1,
  input  logic [MEM_AWIDTH-1:0] addr0,
  input  logic [MEM_AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0]     wdata0,
  input  logic [DWIDTH-1:0]     wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  err0,
  output logic                  err1,
  output logic [DWIDTH-1:0]     rdata,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [2:0]            mem_size,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DWIDTH-1:0]     mem_rdata,
  output logic                  grant,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Timer value on the last WAIT cycle before the watchdog fires.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0] state_r;
  logic       last_grant_r;
  logic [7:0] timer_r;
  logic       win_s;

  // Winner selection for the IDLE grant decision.
  always_comb begin
    win_s = 1'b0;
    if (req0 && req1) begin
      // Tie: fixed priority favours port 0, otherwise alternate away from last winner.
      win_s = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_r;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Access FSM with registered command, completion and status outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      timer_r      <= 8'd0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdata        <= '0;
      mem_req      <= 1'b0;
      mem_write    <= 1'b0;
      mem_size     <= 3'b000;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      grant        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Pulse outputs default low; they are raised for exactly one cycle below.
      mem_req <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req0 || req1) begin
            grant     <= win_s;
            mem_write <= win_s ? wr1 : wr0;
            mem_size  <= win_s ? size1 : size0;
            mem_addr  <= win_s ? addr1 : addr0;
            mem_wdata <= win_s ? wdata1 : wdata0;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            state_r   <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // The controller may complete in the same cycle as the request pulse.
          if (mem_ack) begin
            rdata   <= mem_rdata;
            ack0    <= ~grant;
            ack1    <= grant;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            rdata   <= mem_rdata;
            ack0    <= ~grant;
            ack1    <= grant;
            state_r <= ST_DONE;
          end else if (timer_r == TIMER_LAST) begin
            rdata   <= '0;
            ack0    <= ~grant;
            ack1    <= grant;
            err0    <= ~grant;
            err1    <= grant;
            state_r <= ST_DONE;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        ST_DONE: begin
          // ack/err are visible during this cycle; a late mem_ack here is ignored.
          last_grant_r <= grant;
          timer_r      <= 8'd0;
          busy         <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          timer_r <= 8'd0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsram_port_arbiter.sv
// Directed bench for lsram_port_arbiter. Instance u_rr is round-robin,
// instance u_fp is fixed-priority; both share stimulus and use an 8-cycle
// watchdog. Inputs are driven and outputs sampled on the falling edge.
module tb_lsram_port_arbiter;

  logic        HCLK;
  logic        HRESET;
  logic        req0, req1, wr0, wr1;
  logic [2:0]  size0, size1;
  logic [18:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        ack0, ack1, err0, err1, mem_req, mem_write, grant, busy;
  logic [31:0] rdata, mem_wdata;
  logic [2:0]  mem_size;
  logic [18:0] mem_addr;

  logic        f_ack0, f_ack1, f_err0, f_err1, f_mem_req, f_mem_write, f_grant, f_busy;
  logic [31:0] f_rdata, f_mem_wdata;
  logic [2:0]  f_mem_size;
  logic [18:0] f_mem_addr;

  int total = 0;
  int bad   = 0;

  lsram_port_arbiter #(.MEM_AWIDTH(19), .DWIDTH(32), .FIXED_PRIO(0), .TIMEOUT_CYC(8)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  lsram_port_arbiter #(.MEM_AWIDTH(19), .DWIDTH(32), .FIXED_PRIO(1), .TIMEOUT_CYC(8)) u_fp (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(f_ack0), .ack1(f_ack1), .err0(f_err0), .err1(f_err1), .rdata(f_rdata),
    .mem_req(f_mem_req), .mem_write(f_mem_write), .mem_size(f_mem_size),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant(f_grant), .busy(f_busy)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step();
    @(negedge HCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET = 1'b1;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    size0 = 3'b010; size1 = 3'b010;
    addr0 = 19'h0; addr1 = 19'h0;
    wdata0 = 32'h0; wdata1 = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    step(); step();

    // Reset state
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ack",   32'({ack0, ack1, err0, err1}), 32'd0);
    chk("rst_mreq",  32'(mem_req), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_cmd",   32'(mem_addr) ^ mem_wdata ^ 32'({mem_write, mem_size}), 32'd0);
    chk("fp_rst_ctl", 32'({f_ack0, f_ack1, f_err0, f_err1, f_mem_req, f_mem_write, f_mem_size, f_grant, f_busy}), 32'd0);
    chk("fp_rst_data", f_rdata ^ f_mem_wdata ^ 32'(f_mem_addr), 32'd0);
    HRESET = 1'b0;
    step();

    // 1: port 0 read, ack in ISSUE cycle, minimum latency
    req0 = 1'b1; wr0 = 1'b0; size0 = 3'b010; addr0 = 19'h00010;
    step();
    chk("t1_mreq",  32'(mem_req), 32'd1);
    chk("t1_addr",  32'(mem_addr), 32'h10);
    chk("t1_size",  32'(mem_size), 32'd2);
    chk("t1_grant", 32'(grant), 32'd0);
    chk("t1_noack", 32'(ack0), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("t1_ack0",  32'(ack0), 32'd1);
    chk("t1_err0",  32'(err0), 32'd0);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_mreq_once", 32'(mem_req), 32'd0);
    req0 = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    step();
    chk("t1_ack_pulse", 32'(ack0), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: both requesting; RR alternates from reset, fixed priority starves port 1
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = 19'h00100; addr1 = 19'h00200;
    mem_ack = 1'b1; mem_rdata = 32'h11110000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_grant", 32'(grant), 32'(i % 2));
      chk("rr_addr",  32'(mem_addr), (i % 2 == 1) ? 32'h200 : 32'h100);
      chk("fp_grant", 32'(f_grant), 32'd0);
      step();
      chk("rr_ack0", 32'(ack0), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ack1", 32'(ack1), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("fp_ack0", 32'(f_ack0), 32'd1);
      chk("fp_ack1", 32'(f_ack1), 32'd0);
      step();
    end
    req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
    step();
    chk("t2_idle", 32'(busy), 32'd0);

    // 3: port 1 byte write at top address, ack in 5th WAIT cycle
    req1 = 1'b1; wr1 = 1'b1; size1 = 3'b000; addr1 = 19'h7FFFF; wdata1 = 32'h000000A5;
    step();
    chk("t3_mreq",  32'(mem_req), 32'd1);
    chk("t3_addr",  32'(mem_addr), 32'h7FFFF);
    chk("t3_size",  32'(mem_size), 32'd0);
    chk("t3_write", 32'(mem_write), 32'd1);
    chk("t3_wdata", mem_wdata, 32'hA5);
    chk("t3_grant", 32'(grant), 32'd1);
    step();
    chk("t3_w_mreq", 32'(mem_req), 32'd0);
    chk("t3_w_busy", 32'(busy), 32'd1);
    for (int k = 2; k <= 5; k++) step();
    chk("t3_w5_noack", 32'(ack1), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    chk("t3_ack1",  32'(ack1), 32'd1);
    chk("t3_ack0",  32'(ack0), 32'd0);
    chk("t3_err1",  32'(err1), 32'd0);
    chk("t3_rdata", rdata, 32'h12345678);
    chk("t3_addr_hold", 32'(mem_addr), 32'h7FFFF);
    req1 = 1'b0; wr1 = 1'b0; mem_ack = 1'b0;
    step();
    chk("t3_ack_pulse", 32'(ack1), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: watchdog expiry after 8 WAIT cycles, late ack ignored, next access clean
    req0 = 1'b1; wr0 = 1'b0; size0 = 3'b010; addr0 = 19'h00040;
    step();
    step();
    for (int k = 2; k <= 8; k++) step();
    chk("t4_w8_busy", 32'(busy), 32'd1);
    chk("t4_w8_noack", 32'(ack0), 32'd0);
    step();
    chk("t4_ack0",  32'(ack0), 32'd1);
    chk("t4_err0",  32'(err0), 32'd1);
    chk("t4_rdata", rdata, 32'd0);
    req0 = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    chk("t4_ack_pulse", 32'({ack0, err0}), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    step();
    chk("t4_late_busy",  32'(busy), 32'd0);
    chk("t4_late_rdata", rdata, 32'd0);
    mem_ack = 1'b0;
    req0 = 1'b1; addr0 = 19'h00044;
    step();
    chk("t4_next_addr", 32'(mem_addr), 32'h44);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    chk("t4_next_ack",   32'(ack0), 32'd1);
    chk("t4_next_err",   32'(err0), 32'd0);
    chk("t4_next_rdata", rdata, 32'hCAFEF00D);
    req0 = 1'b0; mem_ack = 1'b0;
    step();

    // 5: reset during WAIT aborts without ack, then a fresh request is served
    req0 = 1'b1; addr0 = 19'h00080;
    step(); step(); step();
    chk("t5_busy", 32'(busy), 32'd1);
    HRESET = 1'b1; req0 = 1'b0;
    step();
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_addr", 32'(mem_addr), 32'd0);
    chk("t5_rst_ack",  32'({ack0, ack1, err0, err1, mem_req, grant}), 32'd0);
    chk("t5_rst_rdata", rdata, 32'd0);
    HRESET = 1'b0;
    step();
    req0 = 1'b1; addr0 = 19'h00084;
    step();
    chk("t5_mreq", 32'(mem_req), 32'd1);
    chk("t5_addr", 32'(mem_addr), 32'h84);
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    step();
    chk("t5_ack0",  32'(ack0), 32'd1);
    chk("t5_rdata", rdata, 32'h55AA55AA);
    req0 = 1'b0; mem_ack = 1'b0;
    step();

    // 6: address change during WAIT does not disturb the latched command
    req0 = 1'b1; addr0 = 19'h00100;
    step();
    step();
    addr0 = 19'h001FC;
    step();
    chk("t6_wait_addr", 32'(mem_addr), 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    chk("t6_done_addr", 32'(mem_addr), 32'h100);
    chk("t6_ack0",  32'(ack0), 32'd1);
    chk("t6_rdata", rdata, 32'h0BADF00D);
    req0 = 1'b0; mem_ack = 1'b0;
    step();
    req0 = 1'b1;
    step();
    chk("t6_new_addr", 32'(mem_addr), 32'h1FC);
    mem_ack = 1'b1;
    step();
    req0 = 1'b0; mem_ack = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
